// File: rtl/cache_ctrl.sv
// Sequencing controller for a 4-way set-associative tag store: lookup, victim choice,
// dirty writeback and line fill over a request/done memory handshake, then tag install.
module cache_ctrl #(
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = 6,
    parameter int INDEX_W  = 15,
    parameter int WAYS     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_write,
    output logic              resp_valid,
    output logic              resp_hit,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_write,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_done,
    output logic              busy
);

    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
    localparam int SETS  = 1 << INDEX_W;

    typedef enum logic [2:0] {
        INIT, IDLE, LOOKUP, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, INSTALL
    } state_t;

    state_t state, next_state;

    logic [INDEX_W-1:0] sweep_idx;
    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_index;
    logic               req_wr;
    logic [1:0]         victim_way;
    logic [TAG_W-1:0]   victim_tag;

    logic [WAYS-1:0]  valid_bits [0:SETS-1];
    logic [WAYS-1:0]  dirty_bits [0:SETS-1];
    logic [TAG_W-1:0] tag_store  [0:SETS-1][0:WAYS-1];
    logic [2:0]       plru_bits  [0:SETS-1];

    logic       hit;
    logic [1:0] hit_way;
    logic       has_invalid;
    logic [1:0] first_invalid;
    logic [1:0] victim_sel;
    logic       victim_dirty;
    logic       offset_unused;

    assign offset_unused = ^req_addr[OFFSET_W-1:0];

    // Tree PLRU: b0 picks the half, b1/b2 pick within the half; bits point at the victim.
    function automatic logic [2:0] plru_touch(input logic [2:0] bits, input logic [1:0] way);
        logic [2:0] t;
        t    = bits;
        t[0] = ~way[1];
        if (!way[1])
            t[1] = ~way[0];
        else
            t[2] = ~way[0];
        return t;
    endfunction

    function automatic logic [1:0] plru_victim(input logic [2:0] bits);
        return bits[0] ? {1'b1, bits[2]} : {1'b0, bits[1]};
    endfunction

    always_comb begin
        hit           = 1'b0;
        hit_way       = 2'd0;
        has_invalid   = 1'b0;
        first_invalid = 2'd0;
        // Descending scan so the lowest-numbered invalid way wins.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_bits[req_index][w] && tag_store[req_index][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = w[1:0];
            end
            if (!valid_bits[req_index][w]) begin
                has_invalid   = 1'b1;
                first_invalid = w[1:0];
            end
        end
        victim_sel   = has_invalid ? first_invalid : plru_victim(plru_bits[req_index]);
        victim_dirty = valid_bits[req_index][victim_sel] && dirty_bits[req_index][victim_sel];
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= INIT;
        else
            state <= next_state;
    end

    // A mem_done arriving in the handshake cycle skips the wait state so it is not lost.
    always_comb begin
        next_state    = state;
        req_ready     = 1'b0;
        busy          = 1'b1;
        mem_req_valid = 1'b0;
        mem_req_write = 1'b0;
        mem_req_addr  = '0;
        case (state)
            INIT: begin
                if (sweep_idx == {INDEX_W{1'b1}})
                    next_state = IDLE;
            end
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid)
                    next_state = LOOKUP;
            end
            LOOKUP: begin
                if (hit)
                    next_state = IDLE;
                else if (victim_dirty)
                    next_state = WB_REQ;
                else
                    next_state = FILL_REQ;
            end
            WB_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_write = 1'b1;
                mem_req_addr  = {victim_tag, req_index, {OFFSET_W{1'b0}}};
                if (mem_req_ready)
                    next_state = mem_done ? FILL_REQ : WB_WAIT;
            end
            WB_WAIT: begin
                if (mem_done)
                    next_state = FILL_REQ;
            end
            FILL_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {req_tag, req_index, {OFFSET_W{1'b0}}};
                if (mem_req_ready)
                    next_state = mem_done ? INSTALL : FILL_WAIT;
            end
            FILL_WAIT: begin
                if (mem_done)
                    next_state = INSTALL;
            end
            INSTALL: begin
                next_state = IDLE;
            end
            default: next_state = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sweep_idx  <= '0;
            req_tag    <= '0;
            req_index  <= '0;
            req_wr     <= 1'b0;
            victim_way <= 2'd0;
            victim_tag <= '0;
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
            case (state)
                INIT: sweep_idx <= sweep_idx + 1'b1;
                IDLE: begin
                    if (req_valid) begin
                        req_tag   <= req_addr[ADDR_W-1 -: TAG_W];
                        req_index <= req_addr[OFFSET_W +: INDEX_W];
                        req_wr    <= req_write;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        resp_valid <= 1'b1;
                        resp_hit   <= 1'b1;
                    end else begin
                        victim_way <= victim_sel;
                        victim_tag <= tag_store[req_index][victim_sel];
                    end
                end
                INSTALL: resp_valid <= 1'b1;
                default: ;
            endcase
        end
    end

    // Tag store has no reset of its own; the INIT sweep clears it one set per cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            case (state)
                INIT: begin
                    valid_bits[sweep_idx] <= '0;
                    dirty_bits[sweep_idx] <= '0;
                    plru_bits[sweep_idx]  <= 3'b000;
                end
                LOOKUP: begin
                    if (hit) begin
                        plru_bits[req_index] <= plru_touch(plru_bits[req_index], hit_way);
                        if (req_wr)
                            dirty_bits[req_index][hit_way] <= 1'b1;
                    end
                end
                INSTALL: begin
                    tag_store[req_index][victim_way]  <= req_tag;
                    valid_bits[req_index][victim_way] <= 1'b1;
                    dirty_bits[req_index][victim_way] <= req_wr;
                    plru_bits[req_index] <= plru_touch(plru_bits[req_index], victim_way);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// Randomized and directed bench for cache_ctrl (INDEX_W=4) against an array-based
// model of the tag store, with a scripted memory responder.
module tb_cache_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic        resp_valid;
    logic        resp_hit;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_write;
    logic [31:0] mem_req_addr;
    logic        mem_done;
    logic        busy;

    cache_ctrl #(.ADDR_W(32), .OFFSET_W(6), .INDEX_W(4), .WAYS(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_write    (req_write),
        .resp_valid   (resp_valid),
        .resp_hit     (resp_hit),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_write(mem_req_write),
        .mem_req_addr (mem_req_addr),
        .mem_done     (mem_done),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_pass;

    bit          m_valid [16][4];
    bit          m_dirty [16][4];
    logic [21:0] m_tag   [16][4];
    logic [2:0]  m_plru  [16];

    logic [31:0] last_wb_addr;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected)
            n_pass++;
        else
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic model_clear();
        for (int s = 0; s < 16; s++) begin
            m_plru[s] = 3'b000;
            for (int w = 0; w < 4; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
                m_tag[s][w]   = '0;
            end
        end
    endtask

    function automatic int model_lookup(input logic [31:0] a);
        int s;
        s = int'(a[9:6]);
        for (int w = 0; w < 4; w++)
            if (m_valid[s][w] && m_tag[s][w] == a[31:10])
                return w;
        return -1;
    endfunction

    function automatic int model_victim(input int s);
        for (int w = 0; w < 4; w++)
            if (!m_valid[s][w])
                return w;
        if (m_plru[s][0] == 1'b0)
            return m_plru[s][1] ? 1 : 0;
        return m_plru[s][2] ? 3 : 2;
    endfunction

    task automatic model_touch(input int s, input int w);
        if (w < 2) begin
            m_plru[s][0] = 1'b1;
            m_plru[s][1] = (w == 0);
        end else begin
            m_plru[s][0] = 1'b0;
            m_plru[s][2] = (w == 2);
        end
    endtask

    // Reset with rst held over two edges, then watch the 16-cycle init sweep.
    task automatic doReset(input bit pulse_done);
        @(negedge clk);
        rst           = 1'b1;
        req_valid     = 1'b0;
        mem_req_ready = 1'b0;
        mem_done      = 1'b0;
        @(negedge clk);
        checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("rst_resp_hit", 32'(resp_hit), 32'd0);
        checkOutput("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        checkOutput("rst_mem_req_write", 32'(mem_req_write), 32'd0);
        checkOutput("rst_mem_req_addr", mem_req_addr, 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        if (pulse_done)
            mem_done = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            checkOutput($sformatf("init_req_ready_c%0d", i), 32'(req_ready), (i >= 17) ? 32'd1 : 32'd0);
            checkOutput("init_mem_req_valid", 32'(mem_req_valid), 32'd0);
            checkOutput("init_resp_valid", 32'(resp_valid), 32'd0);
            @(negedge clk);
            mem_done = 1'b0;
        end
        model_clear();
    endtask

    // One memory transaction; returns at the negedge where mem_done has been driven high.
    task automatic memPhase(input logic [31:0] exp_addr, input bit exp_wr,
                            input int ready_delay, input int done_delay, input string name);
        int guard;
        guard = 0;
        @(negedge clk);
        mem_done      = 1'b0;
        mem_req_ready = 1'b0;
        while (!mem_req_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!mem_req_valid) begin
            checkOutput({name, "_req_timeout"}, 32'd0, 32'd1);
            return;
        end
        checkOutput({name, "_addr"}, mem_req_addr, exp_addr);
        checkOutput({name, "_write"}, 32'(mem_req_write), 32'(exp_wr));
        if (exp_wr)
            last_wb_addr = mem_req_addr;
        for (int i = 0; i < ready_delay; i++) begin
            @(negedge clk);
            checkOutput({name, "_stall_valid"}, 32'(mem_req_valid), 32'd1);
            checkOutput({name, "_stall_addr"}, mem_req_addr, exp_addr);
            checkOutput({name, "_stall_req_ready"}, 32'(req_ready), 32'd0);
        end
        mem_req_ready = 1'b1;
        if (done_delay == 0) begin
            mem_done = 1'b1;
        end else begin
            @(negedge clk);
            mem_req_ready = 1'b0;
            for (int i = 1; i < done_delay; i++)
                @(negedge clk);
            mem_done = 1'b1;
        end
    endtask

    // Issue one CPU request and check the whole response against the model.
    task automatic applyStimulus(input logic [31:0] addr, input bit wr,
                                 input int ready_delay, input int done_delay);
        int s;
        int hit_w;
        int victim;
        bit need_wb;
        logic [31:0] wb_addr;
        int guard;
        s       = int'(addr[9:6]);
        hit_w   = model_lookup(addr);
        victim  = 0;
        need_wb = 1'b0;
        wb_addr = '0;
        if (hit_w < 0) begin
            victim  = model_victim(s);
            need_wb = m_valid[s][victim] && m_dirty[s][victim];
            wb_addr = {m_tag[s][victim], addr[9:6], 6'b0};
        end
        guard = 0;
        while (!req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            checkOutput("req_ready_timeout", 32'd0, 32'd1);
            return;
        end
        req_valid = 1'b1;
        req_addr  = addr;
        req_write = wr;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        checkOutput("lookup_req_ready", 32'(req_ready), 32'd0);
        if (hit_w >= 0) begin
            @(negedge clk);
            checkOutput("hit_resp_valid", 32'(resp_valid), 32'd1);
            checkOutput("hit_resp_hit", 32'(resp_hit), 32'd1);
            checkOutput("hit_req_ready", 32'(req_ready), 32'd1);
            model_touch(s, hit_w);
            if (wr)
                m_dirty[s][hit_w] = 1'b1;
        end else begin
            if (need_wb)
                memPhase(wb_addr, 1'b1, ready_delay, done_delay, "wb");
            memPhase({addr[31:6], 6'b0}, 1'b0, ready_delay, done_delay, "fill");
            @(negedge clk);
            mem_done      = 1'b0;
            mem_req_ready = 1'b0;
            checkOutput("install_resp_valid", 32'(resp_valid), 32'd0);
            @(negedge clk);
            checkOutput("miss_resp_valid", 32'(resp_valid), 32'd1);
            checkOutput("miss_resp_hit", 32'(resp_hit), 32'd0);
            m_tag[s][victim]   = addr[31:10];
            m_valid[s][victim] = 1'b1;
            m_dirty[s][victim] = wr;
            model_touch(s, victim);
        end
    endtask

    initial begin
        int guard;
        logic [31:0] a;
        n_checks      = 0;
        n_pass        = 0;
        rst           = 1'b1;
        req_valid     = 1'b0;
        req_addr      = '0;
        req_write     = 1'b0;
        mem_req_ready = 1'b0;
        mem_done      = 1'b0;
        last_wb_addr  = '0;
        model_clear();

        doReset(1'b0);

        // Miss then hit on the same line with a different offset.
        applyStimulus(32'h0000_0040, 1'b0, 0, 1);
        applyStimulus(32'h0000_0044, 1'b0, 0, 1);

        // Fill set 1 with four written lines, then force an eviction.
        applyStimulus(32'h0000_0040, 1'b1, 0, 1);
        applyStimulus(32'h0000_0440, 1'b1, 1, 2);
        applyStimulus(32'h0000_0840, 1'b1, 0, 0);
        applyStimulus(32'h0000_0C40, 1'b1, 2, 1);
        last_wb_addr = '0;
        applyStimulus(32'h0000_1040, 1'b0, 0, 1);
        checkOutput("evict_wb_addr", last_wb_addr, 32'h0000_0040);

        // Long memory stall while the fill request is pending.
        applyStimulus(32'h0000_2180, 1'b0, 5, 3);

        // Reset while waiting for fill data, with a stray mem_done afterwards.
        guard = 0;
        while (!req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b1;
        req_addr  = 32'h0000_3080;
        req_write = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        guard = 0;
        while (!mem_req_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("rstmid_fill_addr", mem_req_addr, 32'h0000_3080);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        checkOutput("rstmid_busy", 32'(busy), 32'd1);
        doReset(1'b1);
        applyStimulus(32'h0000_0044, 1'b0, 0, 1);
        applyStimulus(32'h0000_2180, 1'b0, 0, 1);

        // Touch order 0,1,2,3,0 in set 2, then miss.
        applyStimulus(32'h0000_0080, 1'b1, 0, 1);
        applyStimulus(32'h0000_0480, 1'b1, 0, 1);
        applyStimulus(32'h0000_0880, 1'b1, 0, 1);
        applyStimulus(32'h0000_0C80, 1'b1, 0, 1);
        applyStimulus(32'h0000_0084, 1'b0, 0, 1);
        checkOutput("touch_plru_model", 32'(dut.plru_bits[2]), 32'(m_plru[2]));
        checkOutput("touch_plru_const", 32'(dut.plru_bits[2]), 32'h3);
        last_wb_addr = '0;
        applyStimulus(32'h0000_1080, 1'b1, 0, 1);
        checkOutput("touch_victim_wb", last_wb_addr, 32'h0000_0880);

        // Random traffic over a few sets and tags to exercise hits, fills and evictions.
        for (int n = 0; n < 80; n++) begin
            a = ($urandom_range(0, 5) << 10) | ($urandom_range(0, 3) << 6) | $urandom_range(0, 63);
            applyStimulus(a, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 2));
            checkOutput("rand_plru", 32'(dut.plru_bits[a[9:6]]), 32'(m_plru[int'(a[9:6])]));
        end

        @(negedge clk);
        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
